// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester front end for the 64K x 8 dual-port RAM.
// Write port and read port are arbitrated independently, each with its
// own round-robin pointer that flips only on a contested grant.
// Optional feature macro: RAM_ARB_FWD_EN enables write-to-read forwarding
// when a same-cycle read and write target the same address.
module ram_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              wr0,
    input  logic              wr1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] ram_wradd,
    output logic [ADDR_W-1:0] ram_rdadd,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic {IDLE, RET} ret_state_e;

    ret_state_e        state_q, state_d;
    logic              ret_id_q, ret_id_d;
    logic              wptr_q, wptr_d;
    logic              rptr_q, rptr_d;
    logic [ADDR_W-1:0] wradd_q, wradd_d;
    logic [ADDR_W-1:0] rdadd_q, rdadd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic wc0, wc1, rc0, rc1;
    logic wgnt0, wgnt1, rgnt0, rgnt1;
    logic wgnt_any, rgnt_any;
    logic [DATA_W-1:0] ret_data;

    // Per-port candidates and round-robin winner; nothing is granted in reset
    always_comb begin
        wc0      = req0 & wr0 & ~rst;
        wc1      = req1 & wr1 & ~rst;
        rc0      = req0 & ~wr0 & ~rst;
        rc1      = req1 & ~wr1 & ~rst;
        wgnt0    = wc0 & (~wc1 | ~wptr_q);
        wgnt1    = wc1 & (~wc0 | wptr_q);
        rgnt0    = rc0 & (~rc1 | ~rptr_q);
        rgnt1    = rc1 & (~rc0 | rptr_q);
        wgnt_any = wgnt0 | wgnt1;
        rgnt_any = rgnt0 | rgnt1;
    end

    // Next-state: pointer flips, held RAM addresses/data, read-return tracking
    always_comb begin
        wptr_d   = (wc0 & wc1) ? ~wptr_q : wptr_q;
        rptr_d   = (rc0 & rc1) ? ~rptr_q : rptr_q;
        wradd_d  = wradd_q;
        wdata_d  = wdata_q;
        rdadd_d  = rdadd_q;
        if (wgnt0) begin
            wradd_d = addr0;
            wdata_d = wdata0;
        end else if (wgnt1) begin
            wradd_d = addr1;
            wdata_d = wdata1;
        end
        if (rgnt0) begin
            rdadd_d = addr0;
        end else if (rgnt1) begin
            rdadd_d = addr1;
        end
        state_d  = rgnt_any ? RET : IDLE;
        ret_id_d = rgnt1;
    end

    // Arbiter and read-return state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            ret_id_q <= 1'b0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            wradd_q  <= '0;
            rdadd_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ret_id_q <= ret_id_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            wradd_q  <= wradd_d;
            rdadd_q  <= rdadd_d;
            wdata_q  <= wdata_d;
        end
    end

`ifdef RAM_ARB_FWD_EN
    logic              fwd_hit_q, fwd_hit_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

    // Detect a same-cycle read/write to one address and remember the write data
    always_comb begin
        fwd_hit_d  = wgnt_any & rgnt_any & (wradd_d == rdadd_d);
        fwd_data_d = wdata_d;
    end

    // Forwarding registers line up with the RAM's one-cycle read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    assign ret_data = fwd_hit_q ? fwd_data_q : ram_rdata;
`else
    assign ret_data = ram_rdata;
`endif

    assign gnt0      = wgnt0 | rgnt0;
    assign gnt1      = wgnt1 | rgnt1;
    assign ram_we    = wgnt_any;
    assign ram_wradd = rst ? '0 : wradd_d;
    assign ram_wdata = rst ? '0 : wdata_d;
    assign ram_rdadd = rst ? '0 : rdadd_d;
    assign rvalid0   = (state_q == RET) & ~ret_id_q & ~rst;
    assign rvalid1   = (state_q == RET) & ret_id_q & ~rst;
    assign rdata     = ((state_q == RET) && !rst) ? ret_data : '0;

endmodule
